// File: rtl/sap1_pkg.sv
// Constants and loader state encoding shared by the SAP-1 RAM, MAR and program loader.
package sap1_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/ram_loader.sv
// Writer side of the SAP-1 program RAM: takes a length/data/checksum frame over valid/ready,
// writes the data from address 0 upward and keeps the CPU held until a frame checks out.
module ram_loader
    import sap1_pkg::*;
#(
    parameter int unsigned ADDR_W = sap1_pkg::ADDR_W,
    parameter int unsigned DATA_W = sap1_pkg::DATA_W,
    parameter int unsigned DEPTH  = sap1_pkg::DEPTH
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // One extra bit so a full-depth frame can count to DEPTH without wrapping.
    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [DATA_W-1:0] MaxLen = DATA_W'(DEPTH);

    loader_state_e     state_q;
    logic [CntW-1:0]   len_q;
    logic [CntW-1:0]   count_q;
    logic [DATA_W-1:0] sum_q;

    logic              accept;
    logic              len_bad;
    logic              last_byte;
    logic [DATA_W-1:0] sum_next;

    always_comb begin
        in_ready = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    end

    assign accept    = in_valid && in_ready;
    assign len_bad   = (in_data == '0) || (in_data > MaxLen);
    assign sum_next  = sum_q + in_data;
    assign last_byte = (count_q + CntW'(1)) == len_q;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q  <= StIdle;
            len_q    <= '0;
            count_q  <= '0;
            sum_q    <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state_q  <= StLen;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        sum_q    <= '0;
                        count_q  <= '0;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                    end
                end
                StLen: begin
                    if (accept) begin
                        if (len_bad) begin
                            state_q <= StErr;
                            error   <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            len_q   <= in_data[CntW-1:0];
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= count_q[ADDR_W-1:0];
                        wr_data <= in_data;
                        sum_q   <= sum_next;
                        count_q <= count_q + CntW'(1);
                        if (last_byte) begin
                            state_q <= StCsum;
                        end
                    end
                end
                StCsum: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (in_data == sum_q) begin
                            state_q  <= StDone;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state_q <= StErr;
                            error   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Writer side of the SAP-1 program RAM, which the CPU only reads.
- Accepts a framed byte stream over a valid/ready handshake: length byte, N program bytes, then a checksum byte.
- Writes the program bytes into RAM from address 0 upward.
- Holds the CPU in clear until a frame is loaded with a correct checksum, replacing file preload as the way programs reach RAM.

Parameters:
ADDR_W, 4, RAM address width
DATA_W, 8, byte and RAM word width
DEPTH, 16, RAM words; largest legal frame length

Ports:
CLK  input  1  system clock, rising edge
CLR  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a new frame
in_valid  input  1  in_data holds a byte
in_data  input  DATA_W  stream byte
in_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  RAM write strobe
wr_addr  output  ADDR_W  RAM write address
wr_data  output  DATA_W  RAM write data
cpu_hold  output  1  drives CPU CLR; 1 = CPU held
busy  output  1  frame in progress
done  output  1  last frame loaded with good checksum
error  output  1  last frame rejected

Behaviour:
- Interface: one clock, CLK. CLR is synchronous and active-high. All outputs are registered except in_ready, which decodes state.
- Reset values: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, busy=0, done=0, error=0, internal count=0, internal sum=0.
- Byte acceptance: a byte is accepted when in_valid && in_ready at the rising edge. in_ready=1 only in LEN, DATA and CSUM.
- IDLE / DONE / ERR:
  - start → LEN. Clears done, error, sum and count; sets busy.
  - Without start, the state holds.
- LEN: on an accepted byte L:
  - L==0 or L>DEPTH → ERR.
  - Otherwise store L → DATA.
- DATA: on each accepted byte:
  - Next cycle: wr_en=1, wr_addr=count, wr_data=byte. Write latency is exactly 1 cycle.
  - sum += byte, modulo 2^DATA_W.
  - count++.
  - When count reaches L after this byte → CSUM.
- CSUM: on the accepted byte C:
  - C==sum → DONE: done=1, cpu_hold=0, busy=0.
  - Otherwise → ERR: error=1, busy=0, cpu_hold stays 1.
- wr_en is a single-cycle pulse per data byte and is never asserted for length or checksum bytes.
- cpu_hold is 1 in every state except DONE. Entering LEN from DONE re-asserts cpu_hold on the same edge, and it stays asserted through a reload.
- start while busy (LEN/DATA/CSUM) is ignored.
- in_valid with in_ready=0 is ignored; no byte is consumed.
- Stalls: in_valid low for any number of cycles mid-frame simply waits; there is no timeout.
- L==DEPTH (16) is legal: addresses 0..15 are written, the count does not wrap, and the last address is 15.
- RAM words at addresses ≥ L are untouched.
- RAM words already written before a checksum failure remain written, but the CPU stays held.
- CLR mid-frame → IDLE with reset values on the next edge.
  - A wr_en pending from the prior edge is dropped.
  - cpu_hold returns to 1.

Decomposition:
- Shared package (sap1_pkg): loader state encoding (IDLE, LEN, DATA, CSUM, DONE, ERR) and the constants ADDR_W/DATA_W/DEPTH shared with the RAM and MAR.
- No sub-module: a single FSM plus counter, accumulator and write register.
- The top-level integration ORs cpu_hold into the CPU CLR, and muxes wr_* into the RAM write port.

Test Plan:
- Good frame: start, bytes 03,1A,2B,3C, checksum 0x81 → writes (0,1A),(1,2B),(2,3C), each 1 cycle after acceptance; done=1; cpu_hold falls to 0; error=0.
- Bad checksum: start, 02,10,20, checksum 0x31 → two writes; error=1; done=0; cpu_hold stays 1; busy=0.
- Illegal length: start, 00 → ERR with no writes. Separately, start, 0x11 → ERR with no writes.
- Full frame with stalls: L=0x10, data 0x00..0x0F, checksum 0x78, in_valid toggled every other cycle → 16 writes at addresses 0..15 with no extra or missing strobes; done=1.
- Reset and reload: CLR asserted after the 2nd data byte of an L=4 frame → IDLE, wr_en=0, cpu_hold=1. A new good frame after that completes normally. A start from DONE re-asserts cpu_hold in that cycle.
- start pulsed mid-frame and in_valid pulsed in IDLE → no effect on state, count or writes.
